btn_direction: RTL and testbench
================================

BTN_DIRECTION -- requirements
Module: btn_direction

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 250000, is the number of consecutive stable clock cycles required to accept a button level change (10 ms at 25 MHz).
REQ-002 Port clock, input, 1, is the 25 MHz pixel clock and the only clock in the block.
REQ-003 Port reset, input, 1, is the reset; it SHALL be synchronous and active-high.
REQ-004 Port button, input, 4, carries raw asynchronous push-buttons ordered {down, right, left, up}; 1 means pressed.
REQ-005 Port vert_sync, input, 1, is the active-low VGA vertical sync from the sync generator.
REQ-006 Port dir, output, 4, is the committed one-hot direction {down, right, left, up} consumed by snake_head.
REQ-007 Port frame_tick, output, 1, is a one-cycle pulse marking the start of each vertical sync.
REQ-008 Port dir_changed, output, 1, is a one-cycle pulse, coincident with frame_tick, asserted when dir takes a new value.
REQ-009 Port led, output, 1, SHALL be high while any debounced button is held.

Function
REQ-010 Each button bit and vert_sync SHALL pass through a two-flop synchronizer before any other use.
REQ-011 Per button: stable level plus counter; counter SHALL clear when synced equals stable, and SHALL increment when it differs.
REQ-012 When the counter reaches DEBOUNCE_CYCLES-1 while still differing, stable SHALL toggle and the counter SHALL clear on that edge.
REQ-013 A press event SHALL be a single-cycle rising edge of a stable bit; release events SHALL be ignored.
REQ-014 Press priority when several events coincide in one cycle SHALL be up > left > right > down; only the winner is considered.
REQ-015 The winning press SHALL load the pending register on the next edge, unless it equals the opposite of committed dir (up/down, left/right); a rejected press SHALL leave pending unchanged.
REQ-016 A later accepted press before commit SHALL overwrite pending; the reverse check SHALL always use committed dir, not pending.
REQ-017 frame_tick SHALL pulse one cycle after the synchronized vert_sync is seen falling (1 -> 0); on that same edge dir SHALL load pending.
REQ-018 dir_changed SHALL assert with frame_tick only if pending differs from the previous dir.
REQ-019 dir SHALL always be exactly one-hot; latency from clean press to dir update SHALL be 2 + DEBOUNCE_CYCLES + 1 cycles to pending, then until the next frame_tick.
REQ-020 A press event and a frame_tick in the same cycle: commit SHALL use the old pending; the new press SHALL land in pending for the following frame.

Reset
REQ-021 On reset: dir = pending = 4'b0100 (right); frame_tick = dir_changed = led = 0; all counters = 0; stable bits and button sync flops = 0; vert_sync sync flops = 1.
REQ-022 Reset asserted mid-debounce SHALL discard the partial count, with no press event generated after release.

Configuration
REQ-023 With macro BTN_DEBOUNCE_EN defined, REQ-011/012 debounce SHALL be compiled in.
REQ-024 Without BTN_DEBOUNCE_EN, stable SHALL equal the synchronized button directly (1-cycle register), for fast simulation; all other behaviour SHALL be unchanged.

Structure
REQ-025 Shared package snake_pkg SHALL hold the DIR_UP/LEFT/RIGHT/DOWN one-hot constants, the opposite-direction function and the DEBOUNCE_CYCLES default.
REQ-026 Per-button synchronizer plus debounce SHALL be sub-module btn_debounce, instantiated four times.

Verification (DEBOUNCE_CYCLES=4, BTN_DEBOUNCE_EN defined)
REQ-027 Reset, then idle 20 cycles with vsync pulses -> dir=0100, dir_changed never asserts, led=0.
REQ-028 Hold up (0001) for 10 cycles, then vsync falls -> frame_tick=1 once, dir=0001, dir_changed=1, led=1 during hold.
REQ-029 Up toggles high 3 cycles / low 1 cycle repeatedly -> no press event, dir stays 0100 across ticks.
REQ-030 dir=0100, clean left press -> rejected; after tick dir=0100, dir_changed=0.
REQ-031 dir=0100, up and down rise in the same cycle -> pending=0001, committed at next tick.
REQ-032 Reset asserted 2 cycles into an up debounce, then released with up still held -> counter restarts; press accepted only after a full 2+4 cycles.

Source files
------------

// File: rtl/snake_pkg.sv
// snake_pkg: constants and helpers shared by the snake input/control blocks.
//   DIR_UP/LEFT/RIGHT/DOWN : one-hot direction codes, bit order {down, right, left, up}
//   opposite_dir()         : the reverse of a one-hot direction ('0 for non one-hot input)
//   DEBOUNCE_CYCLES_DEFAULT: stable cycles needed to accept a button change (10 ms @ 25 MHz)
package snake_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 250000;

  typedef logic [3:0] dir_t;

  localparam dir_t DIR_UP    = 4'b0001;
  localparam dir_t DIR_LEFT  = 4'b0010;
  localparam dir_t DIR_RIGHT = 4'b0100;
  localparam dir_t DIR_DOWN  = 4'b1000;

  function automatic dir_t opposite_dir(input dir_t d);
    dir_t r;
    case (d)
      DIR_UP:    r = DIR_DOWN;
      DIR_DOWN:  r = DIR_UP;
      DIR_LEFT:  r = DIR_RIGHT;
      DIR_RIGHT: r = DIR_LEFT;
      default:   r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: two-flop synchronizer plus debounce for one push-button.
//   clk_i    : clock
//   rst_i    : synchronous active-high reset
//   btn_i    : raw asynchronous button level (1 = pressed)
//   stable_o : debounced button level
//   press_o  : single-cycle pulse on a rising edge of stable_o
// Build option: BTN_DEBOUNCE_EN compiles in the counter-based debounce;
// without it stable_o is simply the synchronized level registered once.
module btn_debounce
  import snake_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic stable_o,
  output logic press_o
);

  logic sync1_q;
  logic sync2_q;
  logic stable_q;
  logic stable_d;
  logic prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      prev_q   <= 1'b0;
    end else begin
      sync1_q  <= btn_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      prev_q   <= stable_q;
    end
  end

`ifdef BTN_DEBOUNCE_EN
  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Count consecutive cycles where the synchronized level disagrees with the
  // accepted level; any agreeing cycle restarts the count.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = ~stable_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = (DEBOUNCE_CYCLES != 0);
  assign stable_d   = sync2_q;
`endif

  assign stable_o = stable_q;
  assign press_o  = stable_q & ~prev_q;

endmodule

// File: rtl/btn_direction.sv
// btn_direction: turns four push-buttons into a committed one-hot snake
// direction that only changes at the start of vertical sync.
//   clock       : 25 MHz pixel clock
//   reset       : synchronous active-high reset
//   button[3:0] : raw buttons {down, right, left, up}, 1 = pressed
//   vert_sync   : active-low VGA vertical sync
//   dir[3:0]    : committed one-hot direction {down, right, left, up}
//   frame_tick  : one-cycle pulse at each vertical sync falling edge
//   dir_changed : one-cycle pulse with frame_tick when dir took a new value
//   led         : high while any debounced button is held
// Build option: BTN_DEBOUNCE_EN enables the debounce counters (see btn_debounce).
module btn_direction
  import snake_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] button,
  input  logic       vert_sync,
  output logic [3:0] dir,
  output logic       frame_tick,
  output logic       dir_changed,
  output logic       led
);

  logic [3:0] stable;
  logic [3:0] press;

  for (genvar i = 0; i < 4; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
      .clk_i   (clock),
      .rst_i   (reset),
      .btn_i   (button[i]),
      .stable_o(stable[i]),
      .press_o (press[i])
    );
  end

  logic vs1_q;
  logic vs2_q;
  logic vs_prev_q;
  logic vs_fall;

  dir_t dir_q;
  dir_t dir_d;
  dir_t pending_q;
  dir_t pending_d;
  dir_t winner;
  logic frame_tick_q;
  logic frame_tick_d;
  logic dir_changed_q;
  logic dir_changed_d;

  assign vs_fall = vs_prev_q & ~vs2_q;

  always_comb begin
    winner = '0;
    if (press[0]) begin
      winner = DIR_UP;
    end else if (press[1]) begin
      winner = DIR_LEFT;
    end else if (press[2]) begin
      winner = DIR_RIGHT;
    end else if (press[3]) begin
      winner = DIR_DOWN;
    end
  end

  // The reverse check uses the committed direction, so a press that is the
  // reverse of what is pending (but not of dir) is still accepted. On a
  // commit edge dir takes the old pending while a new press updates pending.
  always_comb begin
    pending_d     = pending_q;
    dir_d         = dir_q;
    frame_tick_d  = vs_fall;
    dir_changed_d = 1'b0;
    if ((winner != '0) && (winner != opposite_dir(dir_q))) begin
      pending_d = winner;
    end
    if (vs_fall) begin
      dir_d         = pending_q;
      dir_changed_d = (pending_q != dir_q);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vs1_q         <= 1'b1;
      vs2_q         <= 1'b1;
      vs_prev_q     <= 1'b1;
      dir_q         <= DIR_RIGHT;
      pending_q     <= DIR_RIGHT;
      frame_tick_q  <= 1'b0;
      dir_changed_q <= 1'b0;
    end else begin
      vs1_q         <= vert_sync;
      vs2_q         <= vs1_q;
      vs_prev_q     <= vs2_q;
      dir_q         <= dir_d;
      pending_q     <= pending_d;
      frame_tick_q  <= frame_tick_d;
      dir_changed_q <= dir_changed_d;
    end
  end

  assign dir         = dir_q;
  assign frame_tick  = frame_tick_q;
  assign dir_changed = dir_changed_q;
  assign led         = |stable;

endmodule

// File: tb/tb_btn_direction.sv
// Self-checking bench for btn_direction with DEBOUNCE_CYCLES = 4.
// Expectations follow whichever build (BTN_DEBOUNCE_EN defined or not) is compiled.
module tb_btn_direction;

  localparam int unsigned DB = 4;
`ifdef BTN_DEBOUNCE_EN
  localparam int LAT       = 2 + DB + 1;   // button change to pending, in edges
  localparam logic [3:0] GL_DIR = 4'b0100; // glitchy up is filtered
  localparam int GL_DC     = 0;
  localparam int GL_LED    = 0;
`else
  localparam int LAT       = 4;
  localparam logic [3:0] GL_DIR = 4'b0001; // no filtering: up is accepted
  localparam int GL_DC     = 1;
  localparam int GL_LED    = 1;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] button;
  logic       vert_sync;
  logic [3:0] dir;
  logic       frame_tick;
  logic       dir_changed;
  logic       led;

  int checks = 0;
  int errors = 0;

  btn_direction #(
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .button     (button),
    .vert_sync  (vert_sync),
    .dir        (dir),
    .frame_tick (frame_tick),
    .dir_changed(dir_changed),
    .led        (led)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] btn;
    int         hold;
    bit         vs;
    logic [3:0] exp_dir;
    int         exp_ft;
    int         exp_dc;
    logic       exp_led;
  } vec_t;

  vec_t vecs [23];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    chk("dir_onehot", 32'($onehot(dir)), 32'd1);
    chk("changed_without_tick", 32'(dir_changed & ~frame_tick), 32'd0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ticks(3);
    reset = 1'b0;
  endtask

  task automatic vsync_pulse(output int ftc, output int dcc, output logic [3:0] dir_at);
    ftc       = 0;
    dcc       = 0;
    dir_at    = dir;
    vert_sync = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 2) vert_sync = 1'b1;
      if (frame_tick) begin
        ftc++;
        dir_at = dir;
      end
      if (dir_changed) dcc++;
    end
  endtask

  initial begin
    int ftc;
    int dcc;
    logic [3:0] dseen;
    int led_seen;

    //          btn      hold vs  dir      ft dc led
    vecs[0]  = '{4'b0000, 20, 1'b1, 4'b0100, 1, 0, 1'b0};
    vecs[1]  = '{4'b0001, 10, 1'b1, 4'b0001, 1, 1, 1'b1};
    vecs[2]  = '{4'b0000, 10, 1'b1, 4'b0001, 1, 0, 1'b0};
    vecs[3]  = '{4'b0100, 10, 1'b1, 4'b0100, 1, 1, 1'b1};
    vecs[4]  = '{4'b0000, 10, 1'b1, 4'b0100, 1, 0, 1'b0};
    vecs[5]  = '{4'b0010, 10, 1'b1, 4'b0100, 1, 0, 1'b1};
    vecs[6]  = '{4'b0000, 10, 1'b1, 4'b0100, 1, 0, 1'b0};
    vecs[7]  = '{4'b1001, 10, 1'b1, 4'b0001, 1, 1, 1'b1};
    vecs[8]  = '{4'b0000, 10, 1'b1, 4'b0001, 1, 0, 1'b0};
    vecs[9]  = '{4'b1000, 10, 1'b1, 4'b0001, 1, 0, 1'b1};
    vecs[10] = '{4'b0000, 10, 1'b0, 4'b0001, 0, 0, 1'b0};
    vecs[11] = '{4'b0010, 10, 1'b1, 4'b0010, 1, 1, 1'b1};
    vecs[12] = '{4'b0000, 10, 1'b0, 4'b0010, 0, 0, 1'b0};
    vecs[13] = '{4'b1000, 10, 1'b0, 4'b0010, 0, 0, 1'b1};
    vecs[14] = '{4'b0000, 10, 1'b0, 4'b0010, 0, 0, 1'b0};
    vecs[15] = '{4'b0001, 10, 1'b1, 4'b0001, 1, 1, 1'b1};
    vecs[16] = '{4'b0000, 10, 1'b1, 4'b0001, 1, 0, 1'b0};
    vecs[17] = '{4'b0110, 10, 1'b1, 4'b0010, 1, 1, 1'b1};
    vecs[18] = '{4'b0000, 10, 1'b1, 4'b0010, 1, 0, 1'b0};
    vecs[19] = '{4'b1100, 10, 1'b1, 4'b0010, 1, 0, 1'b1};
    vecs[20] = '{4'b0000, 10, 1'b1, 4'b0010, 1, 0, 1'b0};
    vecs[21] = '{4'b0001, 10, 1'b1, 4'b0001, 1, 1, 1'b1};
    vecs[22] = '{4'b0000, 10, 1'b1, 4'b0001, 1, 0, 1'b0};

    button    = 4'b0000;
    vert_sync = 1'b1;
    reset     = 1'b1;
    ticks(2);
    chk("reset_dir", 32'(dir), 32'h4);
    chk("reset_frame_tick", 32'(frame_tick), 32'd0);
    chk("reset_dir_changed", 32'(dir_changed), 32'd0);
    chk("reset_led", 32'(led), 32'd0);
    reset = 1'b0;

    // Up bouncing: 3 cycles high, 1 low, never long enough to be accepted.
    led_seen = 0;
    for (int k = 0; k < 24; k++) begin
      button = ((k % 4) != 3) ? 4'b0001 : 4'b0000;
      tick();
      if (led) led_seen = 1;
    end
    button = 4'b0000;
    ticks(10);
    vsync_pulse(ftc, dcc, dseen);
    chk("glitch_led_seen", 32'(led_seen), 32'(GL_LED));
    chk("glitch_ft", 32'(ftc), 32'd1);
    chk("glitch_dc", 32'(dcc), 32'(GL_DC));
    chk("glitch_dir", 32'(dir), 32'(GL_DIR));

    // Reset in the middle of an up debounce: the count must start over.
    do_reset();
    button = 4'b0001;
    ticks(2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ticks(LAT - 2);
    chk("rst_mid_led_early", 32'(led), 32'd0);
    tick();
    chk("rst_mid_led_set", 32'(led), 32'd1);
    ticks(3);
    vsync_pulse(ftc, dcc, dseen);
    chk("rst_mid_dir", 32'(dir), 32'h1);
    chk("rst_mid_dc", 32'(dcc), 32'd1);
    button = 4'b0000;
    ticks(10);

    do_reset();
    for (int v = 0; v < 23; v++) begin
      button = vecs[v].btn;
      ticks(vecs[v].hold);
      chk($sformatf("v%0d_led", v), 32'(led), 32'(vecs[v].exp_led));
      if (vecs[v].vs) begin
        vsync_pulse(ftc, dcc, dseen);
        chk($sformatf("v%0d_ft", v), 32'(ftc), 32'(vecs[v].exp_ft));
        chk($sformatf("v%0d_dc", v), 32'(dcc), 32'(vecs[v].exp_dc));
        chk($sformatf("v%0d_dir_at_tick", v), 32'(dseen), 32'(vecs[v].exp_dir));
      end
      chk($sformatf("v%0d_dir", v), 32'(dir), 32'(vecs[v].exp_dir));
    end

    // Left press event lands in the same cycle as the vsync fall: the commit
    // keeps the old pending (up), left is committed one frame later.
    button = 4'b0010;
    ticks(LAT - 3);
    vsync_pulse(ftc, dcc, dseen);
    chk("same_cycle_ft", 32'(ftc), 32'd1);
    chk("same_cycle_dir", 32'(dseen), 32'h1);
    chk("same_cycle_dc", 32'(dcc), 32'd0);
    button = 4'b0000;
    ticks(10);
    vsync_pulse(ftc, dcc, dseen);
    chk("next_frame_dir", 32'(dir), 32'h2);
    chk("next_frame_dc", 32'(dcc), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
